mem_port_arbiter: RTL and testbench

Shares the single unified memory port between instruction fetch (IF) and the data-memory stage (MEM) of the pipelined RISC-V core. It sequences one transaction at a time through a request/ready/rvalid memory handshake and returns read data or completion to the owning requester. It drives per-requester stall signals that freeze the pipeline while a request is pending. MEM has priority, and a bounded-starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the data-memory stage.
// DM has priority; a streak counter forces an IF grant after STARVE_LIMIT contended DM grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [3:0]        dm_w_en,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t            r_state;
    owner_t            r_owner;
    logic [SW-1:0]     r_streak;
    logic              r_if_done;
    logic              r_dm_done;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_starved;
    logic w_grant_dm;
    logic w_in_req;
    logic w_dm_own;

    assign w_starved  = (r_streak == SW'(STARVE_LIMIT));
    assign w_grant_dm = dm_req && !(if_req && w_starved);
    assign w_in_req   = (r_state == S_REQ);
    assign w_dm_own   = (r_owner == OWN_DM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= OWN_IF;
            r_streak   <= '0;
            r_if_done  <= 1'b0;
            r_dm_done  <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (if_req || dm_req) begin
                        r_state <= S_REQ;
                        if (w_grant_dm) begin
                            r_owner <= OWN_DM;
                            // only contended DM grants count toward IF starvation
                            if (if_req && !w_starved)
                                r_streak <= r_streak + 1'b1;
                        end else begin
                            r_owner  <= OWN_IF;
                            r_streak <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        if (w_dm_own && (dm_w_en != 4'b0000)) begin
                            r_state   <= S_DONE;
                            r_dm_done <= 1'b1;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        r_state <= S_DONE;
                        if (w_dm_own) begin
                            r_dm_rdata <= mem_rdata;
                            r_dm_done  <= 1'b1;
                        end else begin
                            r_if_rdata <= mem_rdata;
                            r_if_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = w_in_req;
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        if (w_in_req) begin
            if (w_dm_own) begin
                mem_addr  = dm_addr;
                mem_we    = dm_w_en;
                mem_wdata = dm_wdata;
            end else begin
                mem_addr = if_addr;
            end
        end
    end

    assign if_done  = r_if_done;
    assign dm_done  = r_dm_done;
    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;
    assign if_stall = if_req && !r_if_done;
    assign dm_stall = dm_req && !r_dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions with literal expectations, then random
// requester/memory traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [3:0]  dm_w_en = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_w_en(dm_w_en), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Transaction-level model: one in-flight transaction, accepted/answered flags, finish pulse
    bit          m_active = 0;
    bit          m_acc    = 0;
    bit          m_fin    = 0;
    bit          m_dm     = 0;
    int          m_streak = 0;
    logic [31:0] m_if_rd  = '0;
    logic [31:0] m_dm_rd  = '0;
    bit          seen_if_done = 0;
    bit          seen_dm_done = 0;

    logic [3:0] wtab [4] = '{4'h0, 4'h1, 4'h3, 4'hF};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic sample();
        logic        e_mreq;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_we;
        logic        e_ifd;
        logic        e_dmd;
        @(negedge clk);
        e_mreq = m_active && !m_acc;
        e_addr = !e_mreq ? 32'h0 : (m_dm ? dm_addr : if_addr);
        e_we   = (e_mreq && m_dm) ? dm_w_en : 4'h0;
        e_wd   = (e_mreq && m_dm) ? dm_wdata : 32'h0;
        e_ifd  = m_fin && !m_dm;
        e_dmd  = m_fin && m_dm;
        seen_if_done = e_ifd;
        seen_dm_done = e_dmd;
        chk("m_mem_req",   32'(mem_req),   32'(e_mreq));
        chk("m_mem_addr",  mem_addr,       e_addr);
        chk("m_mem_we",    32'(mem_we),    32'(e_we));
        chk("m_mem_wdata", mem_wdata,      e_wd);
        chk("m_if_done",   32'(if_done),   32'(e_ifd));
        chk("m_dm_done",   32'(dm_done),   32'(e_dmd));
        chk("m_if_rdata",  if_rdata,       m_if_rd);
        chk("m_dm_rdata",  dm_rdata,       m_dm_rd);
        chk("m_if_stall",  32'(if_stall),  32'(if_req && !e_ifd));
        chk("m_dm_stall",  32'(dm_stall),  32'(dm_req && !e_dmd));
    endtask

    task automatic adv();
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_active = 0; m_acc = 0; m_fin = 0; m_dm = 0; m_streak = 0;
            m_if_rd = '0; m_dm_rd = '0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (!m_active) begin
            if (if_req || dm_req) begin
                m_dm = dm_req && !(if_req && m_streak >= LIM);
                if (!m_dm) m_streak = 0;
                else if (if_req && m_streak < LIM) m_streak++;
                m_active = 1;
                m_acc    = 0;
            end
        end else if (!m_acc) begin
            if (mem_ready) begin
                if (m_dm && dm_w_en != 4'h0) begin
                    m_active = 0; m_fin = 1;
                end else begin
                    m_acc = 1;
                end
            end
        end else if (mem_rvalid) begin
            if (m_dm) m_dm_rd = mem_rdata;
            else      m_if_rd = mem_rdata;
            m_active = 0; m_acc = 0; m_fin = 1;
        end
        #1;
    endtask

    // One directed transaction: memory accepts after rdly stalled REQ cycles; loads get rvalid
    // the cycle after acceptance. rvalid is also pulsed with junk in IDLE/REQ to show it is ignored.
    task automatic txn(input bit dm, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int unsigned rdly,
                       input string nm);
        bit          st  = dm && (we != 4'h0);
        int unsigned acc = 1 + rdly;
        int unsigned dn  = st ? acc + 1 : acc + 2;
        if (dm) begin
            dm_req = 1'b1; dm_addr = addr; dm_w_en = we; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int unsigned k = 0; k <= dn; k++) begin
            mem_ready = (k == acc);
            if (k <= acc) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
            end else if (k == acc + 1 && !st) begin
                mem_rvalid = 1'b1; mem_rdata = rd;
            end else begin
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
            sample();
            if (k >= 1 && k <= acc) begin
                chk({nm, "_mem_req"},   32'(mem_req), 32'd1);
                chk({nm, "_mem_addr"},  mem_addr, addr);
                chk({nm, "_mem_we"},    32'(mem_we), dm ? 32'(we) : 32'h0);
                chk({nm, "_mem_wdata"}, mem_wdata, dm ? wd : 32'h0);
            end
            chk({nm, "_done"},  32'(dm ? dm_done : if_done),   32'(k == dn));
            chk({nm, "_stall"}, 32'(dm ? dm_stall : if_stall), 32'(k != dn));
            if (k == dn && !st)
                chk({nm, "_rdata"}, dm ? dm_rdata : if_rdata, rd);
            adv();
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        sample();
        adv();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int nd;
        int nif;
        int runs [2];

        // reset with a pending DM request: stall follows req, everything else zero
        rst = 1'b1; dm_req = 1'b1;
        adv();
        sample();
        chk("rst_mem_req",  32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we",   32'(mem_we), 32'd0);
        chk("rst_if_done",  32'(if_done), 32'd0);
        chk("rst_dm_done",  32'(dm_done), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_dm_stall", 32'(dm_stall), 32'd1);
        chk("rst_if_stall", 32'(if_stall), 32'd0);
        adv();
        rst = 1'b0; dm_req = 1'b0;
        sample();
        adv();

        txn(1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h0000_0013, 0, "fetch");
        txn(1'b1, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 3, "sw_bp");
        txn(1'b1, 4'h1, 32'h0000_2001, 32'h0000_00AB, 32'h0, 0, "sb");
        txn(1'b1, 4'h3, 32'h0000_2002, 32'h0000_1234, 32'h0, 1, "sh");
        txn(1'b1, 4'h0, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 2, "lw");
        txn(1'b1, 4'hF, 32'h0000_2008, 32'h1111_2222, 32'h0, 0, "sw2");
        chk("dm_rdata_after_store", dm_rdata, 32'hCAFE_F00D);

        // reset while in RESP; the late rvalid lands in IDLE and must be dropped
        dm_req = 1'b1; dm_addr = 32'h0000_3000; dm_w_en = 4'h0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        sample(); adv();
        mem_ready = 1'b1;
        sample(); chk("rr_req_k1", 32'(mem_req), 32'd1); adv();
        mem_ready = 1'b0; rst = 1'b1;
        sample(); chk("rr_resp_memreq", 32'(mem_req), 32'd0); adv();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        sample();
        chk("rr_no_done",     32'(dm_done), 32'd0);
        chk("rr_dm_rdata0",   dm_rdata, 32'd0);
        chk("rr_if_rdata0",   if_rdata, 32'd0);
        chk("rr_idle_memreq", 32'(mem_req), 32'd0);
        adv();
        mem_rdata = $urandom;
        sample(); chk("rr_rereq", 32'(mem_req), 32'd1); adv();
        mem_ready = 1'b1;
        sample(); adv();
        mem_ready = 1'b0; mem_rdata = 32'h5555_AAAA;
        sample(); chk("rr_resp_nodone", 32'(dm_done), 32'd0); adv();
        mem_rvalid = 1'b0;
        sample();
        chk("rr_done",  32'(dm_done), 32'd1);
        chk("rr_rdata", dm_rdata, 32'h5555_AAAA);
        adv();
        dm_req = 1'b0;
        sample(); adv();

        // contention: both requesters always busy, DM re-requests after every completion
        if_req = 1'b1; if_addr = 32'h0000_0400;
        dm_req = 1'b1; dm_addr = 32'h0000_0800; dm_w_en = 4'h0;
        mem_ready = 1'b1; mem_rvalid = 1'b1;
        nd = 0; nif = 0; runs[0] = -1; runs[1] = -1;
        for (int i = 0; i < 100 && nif < 2; i++) begin
            mem_rdata = $urandom;
            sample();
            if (dm_done) nd++;
            if (if_done) begin
                runs[nif] = nd; nif++; nd = 0;
            end
            adv();
            if (seen_dm_done) dm_addr = dm_addr + 32'd4;
            if (seen_if_done) if_addr = if_addr + 32'd4;
        end
        chk("contend_if_grants", 32'(nif), 32'd2);
        chk("starve_run1", 32'(runs[0]), 32'(LIM));
        chk("starve_run2", 32'(runs[1]), 32'(LIM));
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        sample(); adv();
        sample(); adv();

        // randomized traffic; requests held stable until their completion pulse
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (seen_if_done) begin
                if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
            end else if (!if_req) begin
                if_req = ($urandom_range(0, 2) == 0); if_addr = $urandom;
            end
            if (seen_dm_done || !dm_req) begin
                dm_req   = seen_dm_done ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
                dm_addr  = $urandom;
                dm_w_en  = wtab[$urandom_range(0, 3)];
                dm_wdata = $urandom;
            end
            mem_ready  = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
            sample();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
